fmac_rxfifo_wr_arb: RTL
=======================

# fmac_rxfifo_wr_arb

Frame-level round-robin write arbiter that shares one fmac_fifo4Kx64 instance (single-clock use, wrclk = rdclk = clk) between two frame sources, e.g. the MAC receive path and a loopback/diagnostic injector. It grants whole frames only, never interleaves words of different frames, and admits a frame only when the FIFO has room for its declared length. Writes to the FIFO are registered. Per-port frame counters and error pulses support debug.

## Interface
- DEPTH, 4096: FIFO depth in words. Must match the attached FIFO.
- PTR, 12: log2(DEPTH). Occupancy input is PTR+1 bits wide.
- WIDTH, 64: data word width.
- clk  in  1  single clock for the arbiter and the attached FIFO.
- srst  in  1  synchronous reset, active-high.
- req0 / req1  in  1  port has a frame pending. Held until its first word is accepted.
- len0 / len1  in  9  frame length in words, valid while req is high. 0 encodes 512.
- valid0 / valid1  in  1  data word valid.
- data0 / data1  in  WIDTH  data word.
- eop0 / eop1  in  1  last word of frame, qualified by valid.
- ready0 / ready1  out  1  word accepted when validN & readyN.
- fifo_wrreq  out  1  to FIFO wrreq (registered).
- fifo_data  out  WIDTH  to FIFO data (registered).
- fifo_wrfull  in  1  from FIFO wrfull.
- fifo_wrusedw  in  PTR+1  from FIFO wrusedw.
- gnt  out  2  one-hot current grant. 00 when no port is granted.
- frm_cnt0 / frm_cnt1  out  16  frames completed per port. Wraps at 65535 -> 0.
- err_len0 / err_len1  out  1  one-cycle pulse: frame force-terminated at declared length without eop.
- err_full  out  1  one-cycle pulse: fifo_wrfull seen while a grant is active.

## Operation
- States: IDLE, GNT0, GNT1, SETTLE.
- Effective length: L = (lenN == 0) ? 512 : lenN.
- Free space: free = DEPTH − fifo_wrusedw, computed at PTR+1 bits unsigned. A port is eligible when reqN & (L ≤ free).
- Round-robin pointer rr (1 bit) names the preferred port. Reset value is 0.
- Arbitration in IDLE:
  - If the preferred port has req high: grant it if eligible, otherwise stay in IDLE. It is not bypassed, which prevents starvation of long frames.
  - If the preferred port has no req: grant the other port if eligible.
- On grant:
  - Latch L into a 10-bit word counter wc (counting down).
  - Set gnt.
  - Set rr to the non-granted port.
- In GNTn:
  - readyn = ~fifo_wrfull. The other port's ready is 0.
  - On each accepted word: register fifo_wrreq=1 and fifo_data=datan, then decrement wc.
- Frame end, on the accepted word where eop=1 or wc==1, whichever comes first:
  - Increment frm_cntn.
  - If wc==1 and eop=0: pulse err_len (next cycle). Later words of that frame are the requester's problem; they are treated as a new request.
  - eop before wc==1 is a legal short frame, with no error.
  - Go to SETTLE.
- SETTLE lasts exactly 2 cycles: one for the registered write, one for the FIFO occupancy to update. Then go to IDLE.
- fifo_wrfull during a grant:
  - Ready drops and no word is lost.
  - err_full pulses once per rising edge of fifo_wrfull.
  - The admission check makes this unreachable in correct use.
- srst mid-frame:
  - Return to IDLE, rr=0, counters 0, all outputs 0.
  - The partially written frame stays in the FIFO. Cleanup is owned by the FIFO's aclr, driven by the system.

## Timing
- Reset values: ready0/1=0, fifo_wrreq=0, fifo_data=0, gnt=00, frm_cnt0/1=0, err_len0/1=0, err_full=0.
- Grant latency: req high in IDLE (eligible) at cycle t -> gnt and ready valid at t+1.
- Data latency: word accepted at cycle t -> fifo_wrreq/fifo_data at t+1.
- Throughput: 1 word/cycle within a frame.
- Frame-to-frame gap: accept of the last word at t -> SETTLE at t+1 and t+2 -> IDLE at t+3 -> next grant at t+4.
- len is sampled only in the IDLE grant cycle. Changes after that are ignored.
- Free-space compare uses fifo_wrusedw as seen in IDLE. Concurrent FIFO reads only increase true free space, so the check is always safe.

## Test plan
- Single port, empty FIFO: req0, len0=4, 4 words with eop on the 4th -> gnt=01 one cycle after req, 4 fifo_wrreq pulses with matching data, frm_cnt0=1, FIFO wrusedw=4.
- Both ports continuously requesting with len=2: grants alternate 0,1,0,1 starting with port 0, with a 3-cycle gap between frames.
- Admission block: fifo_wrusedw=4090, req0 len0=8, req1 len1=2, rr=0 -> no grant (port 1 not bypassed). Drain 2 words (wrusedw=4088) -> port 0 granted.
- len0=0 with no eop for 512 words -> frame ends after the 512th word, err_len0 pulses, frm_cnt0 increments.
- Short frame: len1=10, eop on word 3 -> 3 writes, no err_len1, SETTLE entered.
- srst asserted mid-frame after 2 of 5 words -> next cycle gnt=00, ready=0, counters 0. A following req1 gets the first grant only if req0 is low.

Source files
------------

// File: rtl/fmac_rxfifo_wr_arb.sv
// fmac_rxfifo_wr_arb: frame-level round-robin write arbiter in front of one
// shared FIFO. A port gets a grant for a whole frame only when the FIFO has
// room for its declared length. Words reach the FIFO through one register stage.
module fmac_rxfifo_wr_arb #(
  parameter int DEPTH = 4096,
  parameter int PTR   = 12,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             req0,
  input  logic             req1,
  input  logic [8:0]       len0,
  input  logic [8:0]       len1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             eop0,
  input  logic             eop1,
  output logic             ready0,
  output logic             ready1,
  output logic             fifo_wrreq,
  output logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_wrfull,
  input  logic [PTR:0]     fifo_wrusedw,
  output logic [1:0]       gnt,
  output logic [15:0]      frm_cnt0,
  output logic [15:0]      frm_cnt1,
  output logic             err_len0,
  output logic             err_len1,
  output logic             err_full
);

  typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1, ST_SETTLE} state_t;

  localparam logic [PTR:0] LP_DEPTH = (PTR+1)'(DEPTH);

  // A length field of 0 stands for a maximum-size frame of 512 words.
  function automatic logic [9:0] eff_len(input logic [8:0] len);
    return (len == 9'd0) ? 10'd512 : {1'b0, len};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic             r_settle;
  logic [9:0]       r_wc;
  logic             r_wrreq;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_cnt0;
  logic [15:0]      r_cnt1;
  logic             r_err_len0;
  logic             r_err_len1;
  logic             r_err_full;
  logic             r_full_d;

  logic [9:0]       w_len0;
  logic [9:0]       w_len1;
  logic [PTR:0]     w_len0_x;
  logic [PTR:0]     w_len1_x;
  logic [PTR:0]     w_free;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_in_gnt0;
  logic             w_in_gnt1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_last;
  logic             w_end0;
  logic             w_end1;

  assign w_len0   = eff_len(len0);
  assign w_len1   = eff_len(len1);
  assign w_len0_x = {{(PTR-9){1'b0}}, w_len0};
  assign w_len1_x = {{(PTR-9){1'b0}}, w_len1};

  // Occupancy never exceeds DEPTH, so this subtraction cannot wrap.
  assign w_free   = LP_DEPTH - fifo_wrusedw;
  assign w_elig0  = req0 & (w_len0_x <= w_free);
  assign w_elig1  = req1 & (w_len1_x <= w_free);

  assign w_in_gnt0 = (r_state == ST_GNT0);
  assign w_in_gnt1 = (r_state == ST_GNT1);
  assign ready0    = w_in_gnt0 & ~fifo_wrfull;
  assign ready1    = w_in_gnt1 & ~fifo_wrfull;
  assign w_acc0    = valid0 & ready0;
  assign w_acc1    = valid1 & ready1;

  // A frame ends on eop or on its last declared word, whichever comes first.
  assign w_last = (r_wc == 10'd1);
  assign w_end0 = w_acc0 & (eop0 | w_last);
  assign w_end1 = w_acc1 & (eop1 | w_last);

  // Arbitration and frame sequencing; the preferred port is never bypassed while it requests.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rr) begin
          if (req0) w_gnt0 = w_elig0;
          else      w_gnt1 = w_elig1;
        end else begin
          if (req1) w_gnt1 = w_elig1;
          else      w_gnt0 = w_elig0;
        end
        if (w_gnt0)      w_state_nxt = ST_GNT0;
        else if (w_gnt1) w_state_nxt = ST_GNT1;
      end
      ST_GNT0:   if (w_end0) w_state_nxt = ST_SETTLE;
      ST_GNT1:   if (w_end1) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer, remaining-word counter, two-cycle settle timer.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state  <= ST_IDLE;
      r_rr     <= 1'b0;
      r_settle <= 1'b0;
      r_wc     <= 10'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= (r_state == ST_SETTLE) & ~r_settle;
      if (w_gnt0) begin
        r_rr <= 1'b1;
        r_wc <= w_len0;
      end else if (w_gnt1) begin
        r_rr <= 1'b0;
        r_wc <= w_len1;
      end else if (w_acc0 | w_acc1) begin
        r_wc <= r_wc - 10'd1;
      end
    end
  end

  // Registered write into the FIFO: accepted word at t appears on the FIFO port at t+1.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wrreq <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wrreq <= w_acc0 | w_acc1;
      if (w_acc1)      r_data <= data1;
      else if (w_acc0) r_data <= data0;
    end
  end

  // Per-port frame counters and one-cycle debug error pulses.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt0     <= 16'd0;
      r_cnt1     <= 16'd0;
      r_err_len0 <= 1'b0;
      r_err_len1 <= 1'b0;
      r_full_d   <= 1'b0;
      r_err_full <= 1'b0;
    end else begin
      if (w_end0) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_end1) r_cnt1 <= r_cnt1 + 16'd1;
      r_err_len0 <= w_end0 & ~eop0;
      r_err_len1 <= w_end1 & ~eop1;
      r_full_d   <= fifo_wrfull;
      r_err_full <= fifo_wrfull & ~r_full_d & (w_in_gnt0 | w_in_gnt1);
    end
  end

  assign gnt        = {w_in_gnt1, w_in_gnt0};
  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;
  assign frm_cnt0   = r_cnt0;
  assign frm_cnt1   = r_cnt1;
  assign err_len0   = r_err_len0;
  assign err_len1   = r_err_len1;
  assign err_full   = r_err_full;

endmodule
